// File: rtl/alu.sv
// 16-bit datapath ALU: logic, add/sub, compare, immediate and shift ops.
// Result and {Z,C,F,N,L} flags are registered every clock.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  Opcode,
  input  logic        Cin,
  output logic [15:0] C,
  output logic [4:0]  Flags
);

  localparam logic [3:0] CLS_REG   = 4'h0;
  localparam logic [3:0] CLS_ADDI  = 4'h5;
  localparam logic [3:0] CLS_ADDUI = 4'h6;
  localparam logic [3:0] CLS_ADDCI = 4'h7;
  localparam logic [3:0] CLS_SHIFT = 4'h8;
  localparam logic [3:0] CLS_SUBI  = 4'h9;
  localparam logic [3:0] CLS_CMPI  = 4'hB;

  localparam logic [3:0] OP_AND   = 4'h1;
  localparam logic [3:0] OP_OR    = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_NOT   = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_ADDU  = 4'h6;
  localparam logic [3:0] OP_ADDC  = 4'h7;
  localparam logic [3:0] OP_ADDCU = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_CMPU  = 4'hF;

  localparam logic [3:0] SH_LSHI0 = 4'h0;
  localparam logic [3:0] SH_LSHI1 = 4'h1;
  localparam logic [3:0] SH_LSH   = 4'h4;

  function automatic logic [16:0] add17(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'h0000, ci};
  endfunction

  function automatic logic add_ovf(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] r);
    return (a[15] == b[15]) && (r[15] != a[15]);
  endfunction

  function automatic logic sub_ovf(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] r);
    return (a[15] != b[15]) && (r[15] != a[15]);
  endfunction

  logic [15:0] imm_sext_s;
  logic [15:0] imm_zext_s;
  logic [16:0] sum_s;
  logic [15:0] res_s;
  logic        z_from_res_s;
  logic        z_cmp_s;
  logic        z_s;
  logic        carry_s;
  logic        ovf_s;
  logic        neg_s;
  logic        low_s;

  // Decode opcode and compute next result and flags.
  always_comb begin
    imm_sext_s   = {{8{Opcode[3]}}, Opcode[3:0], B[3:0]};
    imm_zext_s   = {8'h00, Opcode[3:0], B[3:0]};
    sum_s        = 17'h0_0000;
    res_s        = 16'h0000;
    z_from_res_s = 1'b0;
    z_cmp_s      = 1'b0;
    carry_s      = 1'b0;
    ovf_s        = 1'b0;
    neg_s        = 1'b0;
    low_s        = 1'b0;

    case (Opcode[7:4])
      CLS_REG: begin
        case (Opcode[3:0])
          OP_AND: begin res_s = A & B; z_from_res_s = 1'b1; end
          OP_OR:  begin res_s = A | B; z_from_res_s = 1'b1; end
          OP_XOR: begin res_s = A ^ B; z_from_res_s = 1'b1; end
          OP_NOT: begin res_s = ~A;    z_from_res_s = 1'b1; end
          OP_ADD: begin
            sum_s = add17(A, B, 1'b0); res_s = sum_s[15:0];
            z_from_res_s = 1'b1; ovf_s = add_ovf(A, B, sum_s[15:0]);
          end
          OP_ADDU: begin
            sum_s = add17(A, B, 1'b0); res_s = sum_s[15:0];
            z_from_res_s = 1'b1; carry_s = sum_s[16];
          end
          OP_ADDC: begin
            sum_s = add17(A, B, Cin); res_s = sum_s[15:0];
            z_from_res_s = 1'b1; carry_s = sum_s[16];
            ovf_s = add_ovf(A, B, sum_s[15:0]);
          end
          OP_ADDCU: begin
            sum_s = add17(A, B, Cin); res_s = sum_s[15:0];
            z_from_res_s = 1'b1; carry_s = sum_s[16];
          end
          OP_SUB: begin
            res_s = A - B; z_from_res_s = 1'b1; ovf_s = sub_ovf(A, B, A - B);
          end
          OP_CMP: begin
            z_cmp_s = (A == B); neg_s = ($signed(A) < $signed(B)); low_s = neg_s;
          end
          OP_CMPU: begin
            z_cmp_s = (A == B); low_s = (A < B);
          end
          default: res_s = 16'h0000;
        endcase
      end
      CLS_ADDI: begin
        sum_s = add17(A, imm_sext_s, 1'b0); res_s = sum_s[15:0];
        z_from_res_s = 1'b1; ovf_s = add_ovf(A, imm_sext_s, sum_s[15:0]);
      end
      CLS_ADDUI: begin
        sum_s = add17(A, imm_zext_s, 1'b0); res_s = sum_s[15:0];
        z_from_res_s = 1'b1; carry_s = sum_s[16];
      end
      CLS_ADDCI: begin
        sum_s = add17(A, imm_sext_s, Cin); res_s = sum_s[15:0];
        z_from_res_s = 1'b1; carry_s = sum_s[16];
        ovf_s = add_ovf(A, imm_sext_s, sum_s[15:0]);
      end
      CLS_SUBI: begin
        res_s = A - imm_sext_s; z_from_res_s = 1'b1;
        ovf_s = sub_ovf(A, imm_sext_s, A - imm_sext_s);
      end
      CLS_CMPI: begin
        z_cmp_s = (A == imm_sext_s);
        neg_s   = ($signed(A) < $signed(imm_sext_s)); low_s = neg_s;
      end
      CLS_SHIFT: begin
        case (Opcode[3:0])
          // Full 16-bit shift amount: anything past bit 15 clears the result.
          SH_LSHI0, SH_LSHI1: begin
            res_s = (B >= 16'd16) ? 16'h0000 : (A << B[3:0]);
            z_from_res_s = 1'b1;
          end
          SH_LSH: begin res_s = {A[14:0], 1'b0}; z_from_res_s = 1'b1; end
          default: res_s = 16'h0000;
        endcase
      end
      default: res_s = 16'h0000;
    endcase

    // Compares report operand equality; reserved ops leave Z clear.
    z_s = z_from_res_s ? (res_s == 16'h0000) : z_cmp_s;
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      C     <= 16'h0000;
      Flags <= 5'b00000;
    end else begin
      C     <= res_s;
      Flags <= {z_s, carry_s, ovf_s, neg_s, low_s};
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, latency sequence,
// and a random all-opcode sweep against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic [7:0]  Opcode;
  logic        Cin;
  logic [15:0] C;
  logic [4:0]  Flags;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
    .Cin    (Cin),
    .C      (C),
    .Flags  (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_c;
    logic [4:0]  exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic rst, input logic [7:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] ec, input logic [4:0] ef);
    vec_t v;
    v.name = nm; v.rst = rst; v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.exp_c = ec; v.exp_f = ef;
    vecs.push_back(v);
  endtask

  task automatic drive_step(input logic rst, input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic cin);
    reset = rst; Opcode = op; A = a; B = b; Cin = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] ec, input logic [4:0] ef);
    n_cmp++;
    if (C !== ec || Flags !== ef) begin
      n_bad++;
      $display("FAIL %s: got C=%h Flags=%b, expected C=%h Flags=%b", nm, C, Flags, ec, ef);
    end
  endtask

  function automatic bit fits16(input int v);
    return (v >= -32768) && (v <= 32767);
  endfunction

  // Reference: ops evaluated with plain integer arithmetic on the operand values.
  function automatic logic [20:0] ref_alu(input logic [7:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    int ua, ub, sa, sb, ci, immu, imms, r;
    logic [15:0] c;
    logic z, cy, f, n, l, zres;
    logic [3:0] cls, sub;
    cls = op[7:4]; sub = op[3:0];
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    ci = cin ? 1 : 0;
    immu = int'(sub) * 16 + int'(b[3:0]);
    imms = (immu >= 128) ? immu - 256 : immu;
    c = 16'h0000; z = 1'b0; cy = 1'b0; f = 1'b0; n = 1'b0; l = 1'b0; zres = 1'b0;
    r = 0;
    if (cls == 4'h0) begin
      case (sub)
        4'h1: begin c = a & b; zres = 1'b1; end
        4'h2: begin c = a | b; zres = 1'b1; end
        4'h3: begin c = a ^ b; zres = 1'b1; end
        4'h4: begin c = ~a;    zres = 1'b1; end
        4'h5: begin r = ua + ub; c = r[15:0]; f = !fits16(sa + sb); zres = 1'b1; end
        4'h6: begin r = ua + ub; c = r[15:0]; cy = (r > 65535); zres = 1'b1; end
        4'h7: begin
          r = ua + ub + ci; c = r[15:0]; cy = (r > 65535);
          f = !fits16(sa + sb + ci); zres = 1'b1;
        end
        4'h8: begin r = ua + ub + ci; c = r[15:0]; cy = (r > 65535); zres = 1'b1; end
        4'h9: begin r = sa - sb; c = r[15:0]; f = !fits16(r); zres = 1'b1; end
        4'hB: begin z = (ua == ub); n = (sa < sb); l = n; end
        4'hF: begin z = (ua == ub); l = (ua < ub); end
        default: ;
      endcase
    end else if (cls == 4'h5) begin
      r = ua + (imms & 65535); c = r[15:0]; f = !fits16(sa + imms); zres = 1'b1;
    end else if (cls == 4'h6) begin
      r = ua + immu; c = r[15:0]; cy = (r > 65535); zres = 1'b1;
    end else if (cls == 4'h7) begin
      r = ua + (imms & 65535) + ci; c = r[15:0]; cy = (r > 65535);
      f = !fits16(sa + imms + ci); zres = 1'b1;
    end else if (cls == 4'h9) begin
      r = sa - imms; c = r[15:0]; f = !fits16(r); zres = 1'b1;
    end else if (cls == 4'hB) begin
      z = (sa == imms); n = (sa < imms); l = n;
    end else if (cls == 4'h8) begin
      if (sub == 4'h0 || sub == 4'h1) begin
        r = (ub >= 16) ? 0 : (ua << ub); c = r[15:0]; zres = 1'b1;
      end else if (sub == 4'h4) begin
        r = ua * 2; c = r[15:0]; zres = 1'b1;
      end
    end
    if (zres) z = (c == 16'h0000);
    return {c, z, cy, f, n, l};
  endfunction

  initial begin
    logic [20:0] exp_v;
    logic [15:0] ra, rb;
    logic        rc;

    reset = 1'b1; A = 16'h0000; B = 16'h0000; Opcode = 8'h00; Cin = 1'b0;

    add_vec("reset",       1'b1, 8'h05, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b00000);
    add_vec("and_release", 1'b0, 8'h01, 16'h0003, 16'h0005, 1'b0, 16'h0001, 5'b00000);
    add_vec("add_ovf",     1'b0, 8'h05, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00100);
    add_vec("addu_carry",  1'b0, 8'h06, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b11000);
    add_vec("addc_cin",    1'b0, 8'h07, 16'h0001, 16'h0002, 1'b1, 16'h0004, 5'b00000);
    add_vec("addc_ovf",    1'b0, 8'h07, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b00100);
    add_vec("addcu_carry", 1'b0, 8'h08, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b11000);
    add_vec("sub_ovf",     1'b0, 8'h09, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b00100);
    add_vec("cmp_lt",      1'b0, 8'h0B, 16'hFFFE, 16'h0003, 1'b0, 16'h0000, 5'b00011);
    add_vec("cmpu_ge",     1'b0, 8'h0F, 16'hFFFE, 16'h0003, 1'b0, 16'h0000, 5'b00000);
    add_vec("cmp_eq",      1'b0, 8'h0B, 16'h1234, 16'h1234, 1'b0, 16'h0000, 5'b10000);
    add_vec("addi_neg",    1'b0, 8'h5F, 16'h0002, 16'h000E, 1'b0, 16'h0000, 5'b10000);
    add_vec("addui",       1'b0, 8'h6F, 16'h0001, 16'h000F, 1'b0, 16'h0100, 5'b00000);
    add_vec("addci_carry", 1'b0, 8'h7F, 16'h0001, 16'h000F, 1'b0, 16'h0000, 5'b11000);
    add_vec("subi_neg",    1'b0, 8'h9F, 16'h0000, 16'h000F, 1'b0, 16'h0001, 5'b00000);
    add_vec("cmpi_lt",     1'b0, 8'hBF, 16'hFFFE, 16'h000F, 1'b0, 16'h0000, 5'b00011);
    add_vec("lshi_4",      1'b0, 8'h80, 16'h0001, 16'h0004, 1'b0, 16'h0010, 5'b00000);
    add_vec("lshi_16",     1'b0, 8'h80, 16'h0001, 16'h0010, 1'b0, 16'h0000, 5'b10000);
    add_vec("lshi_15",     1'b0, 8'h81, 16'h0001, 16'h000F, 1'b0, 16'h8000, 5'b00000);
    add_vec("lsh",         1'b0, 8'h84, 16'h8001, 16'h0000, 1'b0, 16'h0002, 5'b00000);
    add_vec("not_zero",    1'b0, 8'h04, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 5'b10000);
    add_vec("reserved",    1'b0, 8'h3A, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000);
    add_vec("reset_prio",  1'b1, 8'h02, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 5'b00000);
    add_vec("post_reset",  1'b0, 8'h02, 16'h00F0, 16'h000F, 1'b0, 16'h00FF, 5'b00000);

    @(posedge clk); #1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive_step(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      check(vecs[i].name, vecs[i].exp_c, vecs[i].exp_f);
    end

    // Output must hold until the next edge, then flags refresh without sticking.
    drive_step(1'b0, 8'h06, 16'hFFFF, 16'h0002, 1'b0);
    check("seq_addu", 16'h0001, 5'b01000);
    reset = 1'b0; Opcode = 8'h01; A = 16'h0000; B = 16'h0000; Cin = 1'b0;
    #2;
    check("seq_hold", 16'h0001, 5'b01000);
    @(posedge clk); #1;
    check("seq_and", 16'h0000, 5'b10000);

    for (int op = 0; op < 256; op++) begin
      for (int k = 0; k < 4; k++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        if (k == 0) begin
          case ($urandom_range(0, 3))
            0: ra = 16'h0000;
            1: ra = 16'hFFFF;
            2: ra = 16'h7FFF;
            default: ra = 16'h8000;
          endcase
        end
        if (k == 1) rb = 16'($urandom_range(0, 20));
        if (k == 2) rb = ra;
        exp_v = ref_alu(8'(op), ra, rb, rc);
        drive_step(1'b0, 8'(op), ra, rb, rc);
        check($sformatf("sweep_op%02h_a%04h_b%04h_c%0d", op, ra, rb, rc),
              exp_v[20:5], exp_v[4:0]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
